osd_him_wide: RTL

- Host interface module bridging a GLIP byte stream to the on-chip DII debug packet network.
- Next generation of the host bridge, adding:
  - a GLIP width of 16 or 32 bits, with two DII flits packed per 32-bit word;
  - a parametrised egress buffer depth;
  - ingress length checking, with discard and an error counter;
  - idle/pad halfword support.
- Sits between the GLIP backend and the debug interconnect ring.

---
 rtl/osd_him_wide.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/osd_him_wide.sv
// osd_him_wide: GLIP <-> DII host bridge, 16/32-bit GLIP.
// Length-checked ingress, packet-buffered egress with size header.
module osd_him_wide #(
    parameter int GLIP_WIDTH  = 16,
    parameter int BUF_SIZE    = 8,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GLIP_WIDTH-1:0] glip_in_data,
    input  logic                  glip_in_valid,
    output logic                  glip_in_ready,
    output logic [GLIP_WIDTH-1:0] glip_out_data,
    output logic                  glip_out_valid,
    input  logic                  glip_out_ready,
    output logic [15:0]           dii_out_data,
    output logic                  dii_out_valid,
    output logic                  dii_out_first,
    output logic                  dii_out_last,
    input  logic                  dii_out_ready,
    input  logic [15:0]           dii_in_data,
    input  logic                  dii_in_valid,
    input  logic                  dii_in_first,
    input  logic                  dii_in_last,
    output logic                  dii_in_ready,
    output logic [7:0]            err_count
);
    localparam bit WIDE = (GLIP_WIDTH == 32);
    localparam int AW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam int CW = $clog2(BUF_SIZE + 1);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

    typedef enum logic [1:0] {I_HDR, I_FWD, I_DISC} in_state_e;
    typedef enum logic [1:0] {E_IDLE, E_HDR, E_PAY} eg_state_e;

    in_state_e i_state_q, i_state_d;
    logic [15:0] rem_q, rem_d;
    logic first_q, first_d;
    logic half_q, half_d;
    logic [7:0] err_q, err_d;
    logic [15:0] raw_hw, in_hw;
    logic can_take, take;

    eg_state_e e_state_q, e_state_d;
    logic [15:0] hold_q, hold_d;
    logic hold_vld_q, hold_vld_d;
    logic [16:0] mem_q [BUF_SIZE];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d, pkts_q, pkts_d;
    logic in_rdy_q, in_rdy_d;
    logic [16:0] head;
    logic buf_valid, wr_en, pop, adv, cur_avail, found;
    logic [4:0] pkt_size;
    logic [15:0] cur_hw, cur_swp;
    logic [AW-1:0] idx;
    int sum;
    logic unused_first;

    assign unused_first = dii_in_first;

    if (WIDE) begin : g_w32
        assign raw_hw = half_q ? glip_in_data[15:0] : glip_in_data[31:16];
        assign glip_out_data = {hold_q, cur_swp};
    end else begin : g_w16
        assign raw_hw = glip_in_data[15:0];
        assign glip_out_data = cur_swp;
    end

    assign in_hw = {raw_hw[7:0], raw_hw[15:8]};
    assign can_take = (i_state_q != I_FWD) || dii_out_ready;
    assign take = glip_in_valid && can_take;
    assign glip_in_ready = can_take && (!WIDE || half_q);
    assign dii_out_data = in_hw;
    assign dii_out_valid = glip_in_valid && (i_state_q == I_FWD);
    assign dii_out_first = first_q;
    assign dii_out_last = (i_state_q == I_FWD) && (rem_q == 16'd1);
    assign err_count = err_q;

    // Ingress: header parse, forward or discard one halfword per step
    always_comb begin
        i_state_d = i_state_q;
        rem_d = rem_q;
        first_d = first_q;
        half_d = half_q;
        err_d = err_q;
        unique case (i_state_q)
            I_HDR: begin
                if (take && in_hw != 16'd0) begin
                    if (in_hw <= MAX_LEN) begin
                        rem_d = in_hw;
                        first_d = 1'b1;
                        i_state_d = I_FWD;
                    end else begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        rem_d = {11'h0, in_hw[4:0]};
                        if (in_hw[4:0] != 5'd0) i_state_d = I_DISC;
                    end
                end
            end
            I_FWD: begin
                if (take) begin
                    rem_d = rem_q - 16'd1;
                    first_d = 1'b0;
                    if (rem_q == 16'd1) i_state_d = I_HDR;
                end
            end
            I_DISC: begin
                if (take) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) i_state_d = I_HDR;
                end
            end
            default: i_state_d = I_HDR;
        endcase
        if (WIDE && take) half_d = ~half_q;
    end

    // Ingress state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state_q <= I_HDR;
            rem_q <= '0;
            first_q <= 1'b0;
            half_q <= 1'b0;
            err_q <= '0;
        end else begin
            i_state_q <= i_state_d;
            rem_q <= rem_d;
            first_q <= first_d;
            half_q <= half_d;
            err_q <= err_d;
        end
    end

    assign head = mem_q[rd_q];
    assign buf_valid = (pkts_q != '0);
    assign dii_in_ready = in_rdy_q;

    // Size of the head packet: distance to the first stored last flit
    always_comb begin
        pkt_size = '0;
        found = 1'b0;
        sum = 0;
        idx = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            sum = int'(rd_q) + i;
            if (sum >= BUF_SIZE) sum = sum - BUF_SIZE;
            idx = AW'(sum);
            if (!found && mem_q[idx][16]) begin
                found = 1'b1;
                pkt_size = 5'(i + 1);
            end
        end
    end

    // Buffer pointers, occupancy and complete-packet count
    always_comb begin
        wr_en = dii_in_valid && in_rdy_q;
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en) wr_d = (wr_q == AW'(BUF_SIZE - 1)) ? '0 : wr_q + 1'b1;
        if (pop) rd_d = (rd_q == AW'(BUF_SIZE - 1)) ? '0 : rd_q + 1'b1;
        cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
        pkts_d = pkts_q + CW'(wr_en && dii_in_last) - CW'(pop && head[16]);
        in_rdy_d = (cnt_d != CW'(BUF_SIZE));
    end

    // Egress: size header then payload, paired into words when wide
    always_comb begin
        e_state_d = e_state_q;
        hold_d = hold_q;
        hold_vld_d = hold_vld_q;
        pop = 1'b0;
        adv = 1'b0;
        glip_out_valid = 1'b0;
        cur_hw = '0;
        cur_avail = 1'b0;
        unique case (e_state_q)
            E_IDLE: cur_avail = hold_vld_q;
            E_HDR: begin
                cur_avail = 1'b1;
                cur_hw = {11'h0, pkt_size};
            end
            E_PAY: begin
                cur_avail = buf_valid;
                cur_hw = head[15:0];
            end
            default: ;
        endcase
        cur_swp = {cur_hw[7:0], cur_hw[15:8]};
        if (WIDE && !hold_vld_q) begin
            adv = cur_avail;
            if (adv) begin
                hold_d = cur_swp;
                hold_vld_d = 1'b1;
            end
        end else begin
            glip_out_valid = cur_avail;
            adv = cur_avail && glip_out_ready;
            if (adv && WIDE) hold_vld_d = 1'b0;
        end
        if (adv) begin
            unique case (e_state_q)
                E_HDR: e_state_d = E_PAY;
                E_PAY: begin
                    pop = 1'b1;
                    if (head[16]) e_state_d = E_IDLE;
                end
                default: ;
            endcase
        end
        if (e_state_q == E_IDLE && !hold_vld_q && buf_valid) e_state_d = E_HDR;
    end

    // Egress and buffer control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_state_q <= E_IDLE;
            hold_q <= '0;
            hold_vld_q <= 1'b0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            pkts_q <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            e_state_q <= e_state_d;
            hold_q <= hold_d;
            hold_vld_q <= hold_vld_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            pkts_q <= pkts_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    // Flit storage, {last, data}
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {dii_in_last, dii_in_data};
    end
endmodule
